// File: rtl/sa_pkg.sv
// Shared types for the systolic-array input staging path.
// Holds the feeder FSM states, default geometry and the lane slicing helper.
package sa_pkg;

    localparam int DEF_BITWIDTH = 16;
    localparam int DEF_LANES    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    // LSB position of lane `lane` inside a beat of `bitwidth`-wide elements.
    function automatic int lane_lsb(input int lane, input int bitwidth);
        return lane * bitwidth;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage data+valid shift register; DEPTH = 0 is a straight wire.
// Latency: DEPTH cycles.
// Backpressure: none, shifts every cycle.
module skew_delay_line #(
    parameter int BITWIDTH = 16,
    parameter int DEPTH    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BITWIDTH-1:0] in_data,
    input  logic                in_valid,
    output logic [BITWIDTH-1:0] out_data,
    output logic                out_valid
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign out_data       = in_data;
            assign out_valid      = in_valid;
        end else begin : g_shift
            logic [BITWIDTH-1:0] dat_q [DEPTH];
            logic [DEPTH-1:0]    vld_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        dat_q[i] <= '0;
                    end
                    vld_q <= '0;
                end else begin
                    dat_q[0] <= in_data;
                    vld_q[0] <= in_valid;
                    for (int i = 1; i < DEPTH; i++) begin
                        dat_q[i] <= dat_q[i-1];
                        vld_q[i] <= vld_q[i-1];
                    end
                end
            end

            assign out_data  = dat_q[DEPTH-1];
            assign out_valid = vld_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sa_skew_feeder.sv
// Skews one tile of beats into a diagonal wavefront for the systolic array.
// Latency: lane j emits 1+j cycles after the beat is accepted.
// Backpressure: in_ready only in STREAM; downstream never stalls.
module sa_skew_feeder
    import sa_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int LANES    = DEF_LANES,
    parameter int DRAM_BW  = BITWIDTH * LANES,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               weight_or_act_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DRAM_BW-1:0] in_data,
    input  logic               in_last,
    output logic [DRAM_BW-1:0] out_data,
    output logic [LANES-1:0]   out_lane_valid,
    output logic               weight_or_act,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   tile_beats
);

    localparam int FLUSH_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'((LANES > 1) ? LANES - 2 : 0);

    state_t               state_q, state_d;
    logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                 done_d;
    logic                 accept;
    logic                 start_ok;
    logic [DRAM_BW-1:0]   beat_q;
    logic                 beat_vld_q;

    assign in_ready = (state_q == STREAM);
    assign accept   = in_valid && in_ready;
    // A start coinciding with done is dropped: the tile is not closed yet.
    assign start_ok = (state_q == IDLE) && start && !done;
    assign busy     = (state_q != IDLE) || done;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept && in_last) begin
                    if (LANES == 1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = FLUSH;
                        flush_cnt_d = '0;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            done        <= done_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            weight_or_act <= 1'b0;
            tile_beats    <= '0;
        end else if (start_ok) begin
            weight_or_act <= weight_or_act_in;
            tile_beats    <= '0;
        end else if (accept && (tile_beats != {CNT_W{1'b1}})) begin
            tile_beats <= tile_beats + 1'b1;
        end
    end

    // Idle cycles load a zero bubble so the array sees harmless zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_q     <= '0;
            beat_vld_q <= 1'b0;
        end else begin
            beat_q     <= accept ? in_data : '0;
            beat_vld_q <= accept;
        end
    end

    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            skew_delay_line #(
                .BITWIDTH (BITWIDTH),
                .DEPTH    (j)
            ) u_delay (
                .clk       (clk),
                .reset     (reset),
                .in_data   (beat_q[lane_lsb(j, BITWIDTH) +: BITWIDTH]),
                .in_valid  (beat_vld_q),
                .out_data  (out_data[lane_lsb(j, BITWIDTH) +: BITWIDTH]),
                .out_valid (out_lane_valid[j])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboarded bench for sa_skew_feeder: per-lane expected (value, cycle) queues.
module tb_sa_skew_feeder;

    localparam int BW    = 16;
    localparam int LN    = 4;
    localparam int DW    = BW * LN;
    localparam int CW    = 16;

    typedef struct {
        logic [BW-1:0] d;
        int            c;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          weight_or_act_in = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic [DW-1:0] out_data;
    logic [LN-1:0] out_lane_valid;
    logic          weight_or_act;
    logic          busy;
    logic          done;
    logic [CW-1:0] tile_beats;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t lane_q [LN][$];
    int   done_q [$];
    exp_t mon_e;
    int   mon_c;

    sa_skew_feeder #(.BITWIDTH(BW), .LANES(LN), .DRAM_BW(DW), .CNT_W(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .weight_or_act_in (weight_or_act_in),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_last          (in_last),
        .out_data         (out_data),
        .out_lane_valid   (out_lane_valid),
        .weight_or_act    (weight_or_act),
        .busy             (busy),
        .done             (done),
        .tile_beats       (tile_beats)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid lane element and every done pulse must match the
    // oldest expectation in value and in cycle; invalid lanes must carry zero.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            for (int j = 0; j < LN; j++) begin
                checks++;
                if (out_lane_valid[j] === 1'b1) begin
                    if (lane_q[j].size() == 0) begin
                        errors++;
                        $display("FAIL lane%0d_stray: got %0h at cyc %0d, required no element", j, out_data[j*BW +: BW], cyc);
                    end else begin
                        mon_e = lane_q[j].pop_front();
                        if (out_data[j*BW +: BW] !== mon_e.d || cyc != mon_e.c) begin
                            errors++;
                            $display("FAIL lane%0d_elem: got %0h at cyc %0d, required %0h at cyc %0d",
                                     j, out_data[j*BW +: BW], cyc, mon_e.d, mon_e.c);
                        end
                    end
                end else if (out_data[j*BW +: BW] !== '0) begin
                    errors++;
                    $display("FAIL lane%0d_bubble: got %0h, required 0", j, out_data[j*BW +: BW]);
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_stray: got done at cyc %0d, required none", cyc);
                end else begin
                    mon_c = done_q.pop_front();
                    if (cyc != mon_c) begin
                        errors++;
                        $display("FAIL done_cycle: got %0d, required %0d", cyc, mon_c);
                    end
                end
            end
        end
    end

    task automatic clear_sb();
        for (int j = 0; j < LN; j++) lane_q[j].delete();
        done_q.delete();
    endtask

    task automatic do_start(input logic woa);
        start = 1'b1;
        weight_or_act_in = woa;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_open: got ready=%b busy=%b, required 1 1", in_ready, busy);
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last, output int acc);
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL beat_ready: got %b, required 1", in_ready);
        end
        acc = cyc + 1;
        for (int j = 0; j < LN; j++) begin
            e.d = d[j*BW +: BW];
            e.c = acc + j;
            lane_q[j].push_back(e);
        end
        if (last) done_q.push_back(acc + LN - 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_done(output int dc);
        int i;
        for (i = 0; i < 40; i++) begin
            if (done === 1'b1) break;
            @(negedge clk);
        end
        dc = cyc;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: got no done in 40 cycles, required a done pulse");
        end
    endtask

    task automatic wait_drain();
        int left;
        for (int i = 0; i < 20; i++) begin
            left = done_q.size();
            for (int j = 0; j < LN; j++) left += lane_q[j].size();
            if (left == 0) break;
            @(negedge clk);
        end
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding items, required 0", left);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_data !== '0 || out_lane_valid !== '0 || weight_or_act !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || tile_beats !== '0) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b dat=%0h vld=%b woa=%b busy=%b done=%b beats=%0d, required all 0",
                     in_ready, out_data, out_lane_valid, weight_or_act, busy, done, tile_beats);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got rdy=%b busy=%b, required 0 0", in_ready, busy);
        end
    endtask

    task automatic test_skew_shape(output int span);
        int a0, a1, a2, dc;
        do_start(1'b0);
        send_beat(64'h0004_0003_0002_0001, 1'b0, a0);
        send_beat(64'h0008_0007_0006_0005, 1'b0, a1);
        send_beat(64'h000c_000b_000a_0009, 1'b1, a2);
        wait_done(dc);
        checks++;
        if (out_lane_valid[3] !== 1'b1 || out_data[3*BW +: BW] !== 16'd12) begin
            errors++;
            $display("FAIL skew_done_lane3: got vld=%b data=%0d, required 1 12", out_lane_valid[3], out_data[3*BW +: BW]);
        end
        checks++;
        if (tile_beats !== 16'd3) begin
            errors++;
            $display("FAIL skew_beats: got %0d, required 3", tile_beats);
        end
        span = dc - a0;
        wait_drain();
    endtask

    task automatic test_bubble(input int ref_span);
        int a0, a1, a2, dc;
        do_start(1'b0);
        send_beat(64'h0004_0003_0002_0001, 1'b0, a0);
        repeat (2) @(negedge clk);
        send_beat(64'h0008_0007_0006_0005, 1'b0, a1);
        send_beat(64'h000c_000b_000a_0009, 1'b1, a2);
        wait_done(dc);
        checks++;
        if (dc - a0 != ref_span + 2) begin
            errors++;
            $display("FAIL bubble_span: got %0d, required %0d", dc - a0, ref_span + 2);
        end
        checks++;
        if (tile_beats !== 16'd3) begin
            errors++;
            $display("FAIL bubble_beats: got %0d, required 3", tile_beats);
        end
        wait_drain();
    endtask

    task automatic test_single_beat();
        int a0, dc;
        do_start(1'b0);
        send_beat(64'hAAAA_BBBB_CCCC_DDDD, 1'b1, a0);
        wait_done(dc);
        checks++;
        if (dc - a0 != 3) begin
            errors++;
            $display("FAIL single_done: got %0d cycles after accept, required 3", dc - a0);
        end
        checks++;
        if (tile_beats !== 16'd1) begin
            errors++;
            $display("FAIL single_beats: got %0d, required 1", tile_beats);
        end
        wait_drain();
    endtask

    task automatic test_tile_type();
        int a0, a1, dc;
        do_start(1'b1);
        weight_or_act_in = 1'b0;
        send_beat(64'h0101_0202_0303_0404, 1'b0, a0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (weight_or_act !== 1'b1 || tile_beats !== 16'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL type_hold: got woa=%b beats=%0d rdy=%b, required 1 1 1", weight_or_act, tile_beats, in_ready);
        end
        send_beat(64'h0505_0606_0707_0808, 1'b1, a1);
        wait_done(dc);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_on_done: got %b, required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || weight_or_act !== 1'b1 || tile_beats !== 16'd2) begin
            errors++;
            $display("FAIL type_after: got busy=%b woa=%b beats=%0d, required 0 1 2", busy, weight_or_act, tile_beats);
        end
        wait_drain();
        do_start(1'b0);
        checks++;
        if (weight_or_act !== 1'b0) begin
            errors++;
            $display("FAIL type_relatch: got %b, required 0", weight_or_act);
        end
        send_beat(64'h0009_0009_0009_0009, 1'b1, a0);
        wait_done(dc);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int a0, a1, dc, b0, b1;
        do_start(1'b0);
        send_beat(64'h1004_1003_1002_1001, 1'b0, a0);
        send_beat(64'h1008_1007_1006_1005, 1'b1, a1);
        wait_done(dc);
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || tile_beats !== 16'd2) begin
            errors++;
            $display("FAIL b2b_ignored: got rdy=%b busy=%b beats=%0d, required 0 0 2", in_ready, busy, tile_beats);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || tile_beats !== 16'd0) begin
            errors++;
            $display("FAIL b2b_accepted: got rdy=%b beats=%0d, required 1 0", in_ready, tile_beats);
        end
        send_beat(64'h2004_2003_2002_2001, 1'b0, b0);
        send_beat(64'h2008_2007_2006_2005, 1'b1, b1);
        wait_done(dc);
        checks++;
        if (tile_beats !== 16'd2 || b0 - a1 != 6) begin
            errors++;
            $display("FAIL b2b_second: got beats=%0d gap=%0d, required 2 6", tile_beats, b0 - a1);
        end
        wait_drain();
    endtask

    task automatic test_reset_midflush();
        int a0, a1, a2;
        do_start(1'b1);
        send_beat(64'h0004_0003_0002_0001, 1'b0, a0);
        send_beat(64'h0008_0007_0006_0005, 1'b0, a1);
        send_beat(64'h000c_000b_000a_0009, 1'b1, a2);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_sb();
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_data !== '0 || out_lane_valid !== '0 || weight_or_act !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || tile_beats !== '0) begin
            errors++;
            $display("FAIL midflush_clear: got rdy=%b dat=%0h vld=%b woa=%b busy=%b done=%b beats=%0d, required all 0",
                     in_ready, out_data, out_lane_valid, weight_or_act, busy, done, tile_beats);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_lane_valid !== '0) begin
            errors++;
            $display("FAIL midflush_after: got rdy=%b busy=%b vld=%b, required 0 0 0", in_ready, busy, out_lane_valid);
        end
    endtask

    initial begin
        int span;
        test_reset();
        test_skew_shape(span);
        test_bubble(span);
        test_single_beat();
        test_tile_type();
        test_back_to_back();
        test_reset_midflush();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
